// File: rtl/edge_evt_sched.sv
// +--------------------------------------------------------------------------+
// | Module   : edge_evt_sched                                                |
// | Desc     : Per-channel edge detector with one pending slot per channel,  |
// |            round-robin arbitration onto a registered valid/ready output. |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
`default_nettype none

module edge_evt_sched #(
  parameter int NCH   = 4,
  parameter int CH_W  = $clog2(NCH),
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             srst,
  input  logic [NCH-1:0]   din,
  input  logic [NCH-1:0]   posedge_trigger,
  input  logic [NCH-1:0]   negedge_trigger,
  output logic             evt_valid,
  input  logic             evt_ready,
  output logic [CH_W-1:0]  evt_ch,
  output logic             evt_pol,
  output logic [NCH-1:0]   ovf,
  output logic [CNT_W-1:0] drop_cnt,
  input  logic             ovf_clr
);

  // Sum is wide enough to hold the counter plus a full cycle of drops before saturation.
  localparam int SUM_W = CNT_W + $clog2(NCH + 1);
  localparam logic [SUM_W-1:0] C_CNT_MAX = {{(SUM_W-CNT_W){1'b0}}, {CNT_W{1'b1}}};

  logic [NCH-1:0]   r_prev;
  logic [NCH-1:0]   r_pend;
  logic [NCH-1:0]   r_pend_pol;
  logic [NCH-1:0]   r_ovf;
  logic [CNT_W-1:0] r_drop_cnt;
  logic [CH_W-1:0]  r_ptr;
  logic             r_evt_valid;
  logic [CH_W-1:0]  r_evt_ch;
  logic             r_evt_pol;

  logic [NCH-1:0]   w_rise;
  logic [NCH-1:0]   w_fall;
  logic [NCH-1:0]   w_edge;
  logic [NCH-1:0]   w_take;
  logic [NCH-1:0]   w_drop;
  logic             w_load;
  logic             w_gnt_any;
  logic [CH_W-1:0]  w_gnt_idx;
  logic [CH_W-1:0]  w_ptr_next;
  logic [SUM_W-1:0] w_ndrop;
  logic [SUM_W-1:0] w_cnt_sum;
  logic [CNT_W-1:0] w_cnt_next;

  assign w_rise = din & ~r_prev & posedge_trigger;
  assign w_fall = ~din & r_prev & negedge_trigger;
  assign w_edge = w_rise | w_fall;
  assign w_load = ~r_evt_valid | evt_ready;
  assign w_drop = w_edge & r_pend & ~w_take;

  // Round-robin scan starting at r_ptr, wrapping modulo NCH.
  always_comb begin
    int idx;
    idx       = 0;
    w_gnt_any = 1'b0;
    w_gnt_idx = '0;
    w_take    = '0;
    for (int k = 0; k < NCH; k++) begin
      idx = int'(r_ptr) + k;
      if (idx >= NCH) idx = idx - NCH;
      if (!w_gnt_any && r_pend[idx]) begin
        w_gnt_any = 1'b1;
        w_gnt_idx = CH_W'(idx);
      end
    end
    if (w_gnt_any && w_load) w_take[w_gnt_idx] = 1'b1;
  end

  assign w_ptr_next = (w_gnt_idx == CH_W'(NCH - 1)) ? '0 : w_gnt_idx + CH_W'(1);

  always_comb begin
    w_ndrop = '0;
    for (int i = 0; i < NCH; i++) w_ndrop = w_ndrop + SUM_W'(w_drop[i]);
  end

  assign w_cnt_sum  = (ovf_clr ? '0 : SUM_W'(r_drop_cnt)) + w_ndrop;
  assign w_cnt_next = (w_cnt_sum > C_CNT_MAX) ? CNT_W'(C_CNT_MAX) : CNT_W'(w_cnt_sum);

  always_ff @(posedge clk) begin
    if (srst) begin
      r_prev     <= '0;
      r_pend     <= '0;
      r_pend_pol <= '0;
      r_ovf      <= '0;
      r_drop_cnt <= '0;
    end else begin
      r_prev     <= din;
      r_ovf      <= (ovf_clr ? '0 : r_ovf) | w_drop;
      r_drop_cnt <= w_cnt_next;
      // A granted slot refilled by a same-cycle edge is a hand-off, never a drop.
      for (int i = 0; i < NCH; i++) begin
        if (w_take[i]) begin
          r_pend[i] <= w_edge[i];
          if (w_edge[i]) r_pend_pol[i] <= w_rise[i];
        end else if (w_edge[i] && !r_pend[i]) begin
          r_pend[i]     <= 1'b1;
          r_pend_pol[i] <= w_rise[i];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      r_evt_valid <= 1'b0;
      r_evt_ch    <= '0;
      r_evt_pol   <= 1'b0;
      r_ptr       <= '0;
    end else if (w_load) begin
      if (w_gnt_any) begin
        r_evt_valid <= 1'b1;
        r_evt_ch    <= w_gnt_idx;
        r_evt_pol   <= r_pend_pol[w_gnt_idx];
        r_ptr       <= w_ptr_next;
      end else begin
        r_evt_valid <= 1'b0;
      end
    end
  end

  assign evt_valid = r_evt_valid;
  assign evt_ch    = r_evt_ch;
  assign evt_pol   = r_evt_pol;
  assign ovf       = r_ovf;
  assign drop_cnt  = r_drop_cnt;

endmodule

`default_nettype wire

// File: tb/tb_edge_evt_sched.sv
// +--------------------------------------------------------------------------+
// | Module   : tb_edge_evt_sched                                             |
// | Desc     : Directed bench for edge_evt_sched with a cycle-level model.   |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_edge_evt_sched;

  localparam int NCH   = 4;
  localparam int CH_W  = 2;
  localparam int CNT_W = 2;
  localparam int C_MAX = (1 << CNT_W) - 1;

  logic             clk;
  logic             srst;
  logic [NCH-1:0]   din;
  logic [NCH-1:0]   posedge_trigger;
  logic [NCH-1:0]   negedge_trigger;
  logic             evt_valid;
  logic             evt_ready;
  logic [CH_W-1:0]  evt_ch;
  logic             evt_pol;
  logic [NCH-1:0]   ovf;
  logic [CNT_W-1:0] drop_cnt;
  logic             ovf_clr;

  edge_evt_sched #(.NCH(NCH), .CH_W(CH_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .srst(srst), .din(din),
    .posedge_trigger(posedge_trigger), .negedge_trigger(negedge_trigger),
    .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_ch(evt_ch),
    .evt_pol(evt_pol), .ovf(ovf), .drop_cnt(drop_cnt), .ovf_clr(ovf_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
  endtask

  // Model state, integer-valued, derived directly from the behavioural rules.
  int m_prev[NCH];
  int m_pend[NCH];
  int m_pol[NCH];
  int m_ovf[NCH];
  int m_ptr = 0;
  int m_valid = 0;
  int m_ch = 0;
  int m_opol = 0;
  int m_cnt = 0;

  always @(posedge clk) begin
    int rise[NCH];
    int fall[NCH];
    int g;
    int drops;
    if (srst) begin
      for (int i = 0; i < NCH; i++) begin
        m_prev[i] = 0; m_pend[i] = 0; m_pol[i] = 0; m_ovf[i] = 0;
      end
      m_ptr = 0; m_valid = 0; m_ch = 0; m_opol = 0; m_cnt = 0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        rise[i] = (din[i] && m_prev[i] == 0 && posedge_trigger[i]) ? 1 : 0;
        fall[i] = (!din[i] && m_prev[i] == 1 && negedge_trigger[i]) ? 1 : 0;
      end
      g = -1;
      if (m_valid == 0 || evt_ready) begin
        for (int k = 0; k < NCH; k++) begin
          if (g < 0 && m_pend[(m_ptr + k) % NCH] == 1) g = (m_ptr + k) % NCH;
        end
        if (g >= 0) begin
          m_valid = 1; m_ch = g; m_opol = m_pol[g]; m_ptr = (g + 1) % NCH;
        end else begin
          m_valid = 0;
        end
      end
      if (ovf_clr) begin
        m_cnt = 0;
        for (int i = 0; i < NCH; i++) m_ovf[i] = 0;
      end
      drops = 0;
      for (int i = 0; i < NCH; i++) begin
        if (i == g) begin
          if (rise[i] + fall[i] > 0) begin m_pend[i] = 1; m_pol[i] = rise[i]; end
          else m_pend[i] = 0;
        end else if (rise[i] + fall[i] > 0) begin
          if (m_pend[i] == 0) begin m_pend[i] = 1; m_pol[i] = rise[i]; end
          else begin m_ovf[i] = 1; drops++; end
        end
        m_prev[i] = din[i];
      end
      m_cnt = (m_cnt + drops > C_MAX) ? C_MAX : m_cnt + drops;
    end
  end

  always @(negedge clk) begin
    int ovf_exp;
    if (chk_en) begin
      ovf_exp = 0;
      for (int i = 0; i < NCH; i++) ovf_exp = ovf_exp | (m_ovf[i] << i);
      check("model_valid", int'(evt_valid), m_valid);
      if (m_valid == 1) begin
        check("model_ch", int'(evt_ch), m_ch);
        check("model_pol", int'(evt_pol), m_opol);
      end
      check("model_ovf", int'(ovf), ovf_exp);
      check("model_cnt", int'(drop_cnt), m_cnt);
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    srst = 1'b1; din = '0; posedge_trigger = '0; negedge_trigger = '0;
    evt_ready = 1'b0; ovf_clr = 1'b0;
    cyc(2);
    check("rst_valid", int'(evt_valid), 0);
    check("rst_ch", int'(evt_ch), 0);
    check("rst_pol", int'(evt_pol), 0);
    check("rst_ovf", int'(ovf), 0);
    check("rst_cnt", int'(drop_cnt), 0);
    srst = 1'b0; chk_en = 1'b1;

    // Single rising edge on ch0: two-cycle latency, one-cycle event, no fall event.
    posedge_trigger = 4'b0001; evt_ready = 1'b1;
    cyc(8);
    din = 4'b0001;
    cyc(1); check("rise_early", int'(evt_valid), 0);
    cyc(1); check("rise_valid", int'(evt_valid), 1);
    check("rise_ch", int'(evt_ch), 0);
    check("rise_pol", int'(evt_pol), 1);
    cyc(1); check("rise_once", int'(evt_valid), 0);
    din = 4'b0000;
    cyc(4); check("no_fall_evt", int'(evt_valid), 0);

    // Both-edge channel 2 with a three-cycle pulse.
    posedge_trigger = 4'b0100; negedge_trigger = 4'b0100;
    din = 4'b0100;
    cyc(2); check("both_r_valid", int'(evt_valid), 1);
    check("both_r_ch", int'(evt_ch), 2);
    check("both_r_pol", int'(evt_pol), 1);
    cyc(1); din = 4'b0000;
    cyc(2); check("both_f_valid", int'(evt_valid), 1);
    check("both_f_ch", int'(evt_ch), 2);
    check("both_f_pol", int'(evt_pol), 0);
    cyc(2);

    // Round-robin burst twice from a freshly reset pointer.
    srst = 1'b1; din = '0; cyc(1); srst = 1'b0;
    posedge_trigger = 4'b1111; negedge_trigger = 4'b0000;
    for (int rep = 0; rep < 2; rep++) begin
      din = 4'b1111;
      cyc(1);
      for (int k = 0; k < NCH; k++) begin
        cyc(1);
        check("rr_valid", int'(evt_valid), 1);
        check("rr_ch", int'(evt_ch), k);
      end
      cyc(1); check("rr_idle", int'(evt_valid), 0);
      din = 4'b0000;
      cyc(2);
    end

    // Backpressure: ch0 occupies the output, ch1 pends, a second ch1 rise drops.
    srst = 1'b1; din = '0; cyc(1); srst = 1'b0;
    posedge_trigger = 4'b0011; evt_ready = 1'b0;
    din = 4'b0001;
    cyc(2); check("bp_hold_ch", int'(evt_ch), 0);
    din = 4'b0011; cyc(1);
    din = 4'b0001; cyc(1);
    din = 4'b0011; cyc(1);
    check("bp_ovf", int'(ovf), 4'b0010);
    check("bp_cnt", int'(drop_cnt), 1);
    check("bp_hold_valid", int'(evt_valid), 1);
    evt_ready = 1'b1;
    cyc(1); check("bp_rel_valid", int'(evt_valid), 1);
    check("bp_rel_ch", int'(evt_ch), 1);
    check("bp_rel_pol", int'(evt_pol), 1);
    cyc(1); check("bp_rel_done", int'(evt_valid), 0);

    // Saturation of the two-bit counter, then clear, then clear racing a drop.
    evt_ready = 1'b0;
    din = 4'b0000; cyc(1);
    din = 4'b0010; cyc(1);
    for (int k = 0; k < 5; k++) begin
      din = 4'b0000; cyc(1);
      din = 4'b0010; cyc(1);
    end
    cyc(1);
    check("sat_cnt", int'(drop_cnt), 3);
    check("sat_ovf", int'(ovf), 4'b0010);
    ovf_clr = 1'b1; cyc(1); ovf_clr = 1'b0;
    check("clr_cnt", int'(drop_cnt), 0);
    check("clr_ovf", int'(ovf), 0);
    din = 4'b0000; cyc(1);
    din = 4'b0010; ovf_clr = 1'b1; cyc(1); ovf_clr = 1'b0;
    check("clr_race_cnt", int'(drop_cnt), 1);
    check("clr_race_ovf", int'(ovf), 4'b0010);

    // Reset while an event is presented and another is pending.
    check("pre_rst_valid", int'(evt_valid), 1);
    srst = 1'b1; din = 4'b0000;
    cyc(1);
    check("mid_rst_valid", int'(evt_valid), 0);
    check("mid_rst_ch", int'(evt_ch), 0);
    check("mid_rst_pol", int'(evt_pol), 0);
    check("mid_rst_ovf", int'(ovf), 0);
    check("mid_rst_cnt", int'(drop_cnt), 0);
    srst = 1'b0; evt_ready = 1'b1;
    cyc(5); check("no_stale", int'(evt_valid), 0);

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
